centroid_wr_arbiter: RTL

- Owns a bank of NUM_CENT 64-bit centroid registers.
- Shares the bank's single write port between NUM_REQ update engines (k-means accumulate/divide lanes) using round-robin arbitration and a valid/ready handshake.
- Provides one registered read port for the distance-compute stage.
- Provides a bank-wide clear and a freeze input so the iteration sequencer can stop updates while centroids are broadcast.

---
 rtl/kmeans_pkg.sv | 12 +
 rtl/centroid_wr_arbiter_rr_arbiter.sv | 53 +++++
 rtl/centroid_wr_arbiter.sv | 116 +++++++++++
 3 files changed

// File: rtl/kmeans_pkg.sv
// Shared k-means definitions: centroid word/index types and default sizes.
package kmeans_pkg;

  localparam int CENT_DATA_W  = 64;
  localparam int NUM_CENT_DEF = 8;
  localparam int NUM_REQ_DEF  = 4;
  localparam int CENT_IDX_W   = $clog2(NUM_CENT_DEF);

  typedef logic [CENT_DATA_W-1:0] cent_word_t;
  typedef logic [CENT_IDX_W-1:0]  cent_idx_t;

endpackage

// File: rtl/centroid_wr_arbiter_rr_arbiter.sv
// Round-robin grant generator with its own rotating priority pointer.
// The grant is combinational from req/ptr; the pointer moves past the winner.
module rr_arbiter #(
  parameter int N  = 4,
  parameter int PW = $clog2(N)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          en,
  input  logic [N-1:0]  req,
  output logic [N-1:0]  gnt,
  output logic          gnt_any,
  output logic [PW-1:0] gnt_idx
);

  logic [PW-1:0] ptr_q, ptr_d;

  // Scan requesters starting at the pointer, wrapping modulo N; first hit wins.
  always_comb begin
    int            j;
    logic [PW-1:0] j_idx;
    gnt     = '0;
    gnt_any = 1'b0;
    gnt_idx = '0;
    j       = 0;
    j_idx   = '0;
    for (int k = 0; k < N; k++) begin
      j = int'(ptr_q) + k;
      if (j >= N) j = j - N;
      j_idx = PW'(j);
      if (en && !gnt_any && req[j_idx]) begin
        gnt[j_idx] = 1'b1;
        gnt_any    = 1'b1;
        gnt_idx    = j_idx;
      end
    end
  end

  // Next pointer: one past the winner (wrapping), otherwise hold.
  always_comb begin
    ptr_d = ptr_q;
    if (gnt_any) begin
      ptr_d = (gnt_idx == PW'(N - 1)) ? '0 : gnt_idx + PW'(1);
    end
  end

  // Pointer register.
  always_ff @(posedge clk) begin
    if (reset) ptr_q <= '0;
    else       ptr_q <= ptr_d;
  end

endmodule

// File: rtl/centroid_wr_arbiter.sv
// Centroid register bank with a round-robin shared write port, one registered
// read port, bank-wide clear and a freeze input that blocks all grants.
// Optional macro CENT_ARB_STALL_CNT_EN adds a saturating stall_cnt output.
module centroid_wr_arbiter
  import kmeans_pkg::*;
#(
  parameter int NUM_REQ  = NUM_REQ_DEF,
  parameter int NUM_CENT = NUM_CENT_DEF,
  parameter int DATA_W   = CENT_DATA_W,
  parameter int IDX_W    = $clog2(NUM_CENT)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      freeze,
  input  logic                      clear,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*IDX_W-1:0]  req_idx,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [IDX_W-1:0]          rd_idx,
  output logic [DATA_W-1:0]         rd_data,
`ifdef CENT_ARB_STALL_CNT_EN
  output logic [15:0]               stall_cnt,
`endif
  output logic                      wr_busy
);

  localparam int RPW = $clog2(NUM_REQ);

  logic [IDX_W-1:0]  idx_arr  [NUM_REQ];
  logic [DATA_W-1:0] data_arr [NUM_REQ];
  logic [DATA_W-1:0] bank_q   [NUM_CENT];
  logic [DATA_W-1:0] bank_d   [NUM_CENT];
  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  logic [IDX_W-1:0]  wr_idx;
  logic [DATA_W-1:0] wr_data;
  logic [RPW-1:0]    gnt_idx;
  logic              gnt_any;
  logic              arb_en;
  logic              rd_in_range;

  // Unpack the per-requester index/data slices.
  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
    assign idx_arr[gi]  = req_idx[gi*IDX_W +: IDX_W];
    assign data_arr[gi] = req_data[gi*DATA_W +: DATA_W];
  end

  // Clear and freeze both withhold grants, so a clear never drops a write.
  assign arb_en = !reset && !freeze && !clear;

  rr_arbiter #(.N(NUM_REQ), .PW(RPW)) u_arb (
    .clk     (clk),
    .reset   (reset),
    .en      (arb_en),
    .req     (req_valid),
    .gnt     (req_ready),
    .gnt_any (gnt_any),
    .gnt_idx (gnt_idx)
  );

  assign wr_busy = gnt_any;
  assign wr_idx  = idx_arr[gnt_idx];
  assign wr_data = data_arr[gnt_idx];

  // Per-entry next state; an out-of-range write index matches no entry and is dropped.
  for (genvar gi = 0; gi < NUM_CENT; gi++) begin : g_bank
    assign bank_d[gi] = clear ? '0 :
                        ((gnt_any && wr_idx == IDX_W'(gi)) ? wr_data : bank_q[gi]);

    // Bank entry register.
    always_ff @(posedge clk) begin
      if (reset) bank_q[gi] <= '0;
      else       bank_q[gi] <= bank_d[gi];
    end
  end

  assign rd_in_range = ({1'b0, rd_idx} < (IDX_W+1)'(NUM_CENT));

  // Read mux samples the pre-update bank, giving old-value-on-collision semantics.
  always_comb begin
    rd_data_d = '0;
    if (rd_in_range) rd_data_d = bank_q[rd_idx];
  end

  // Registered read data.
  always_ff @(posedge clk) begin
    if (reset) rd_data_q <= '0;
    else       rd_data_q <= rd_data_d;
  end

  assign rd_data = rd_data_q;

`ifdef CENT_ARB_STALL_CNT_EN
  logic [15:0] stall_cnt_q, stall_cnt_d;
  logic        stall_hit;

  // A cycle stalls when someone waits with no grant, or when losers are queued.
  assign stall_hit = ((|req_valid) && !gnt_any) || ($countones(req_valid) > 1);

  // Saturating stall counter, zeroed by clear.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (clear)                                   stall_cnt_d = '0;
    else if (stall_hit && stall_cnt_q != 16'hFFFF) stall_cnt_d = stall_cnt_q + 16'd1;
  end

  // Stall counter register.
  always_ff @(posedge clk) begin
    if (reset) stall_cnt_q <= '0;
    else       stall_cnt_q <= stall_cnt_d;
  end

  assign stall_cnt = stall_cnt_q;
`endif

endmodule
